ps2_poly_synth: RTL and testbench
=================================

// Module: ps2_poly_synth
// PURPOSE
//  Polyphonic successor to the single-voice PS/2 keyboard synth. Consumes the
//  byte stream from ps2_keyboard, tracks make/break codes, and allocates up to
//  NUM_VOICES square-wave voices. Mixes the voices with a saturating volume
//  control into a signed audio sample, strobed by wr at a fixed sample rate.
//  The note lookup (KeyToNote) stays external through a combinational port.
// PARAMETERS
//  NUM_VOICES  4          simultaneous voices (power of 2, >=1)
//  HP_W        21         half-period counter width (CLOCK_50 cycles)
//  VOL_W       15         unsigned volume width (VOL_W < SAMPLE_W required)
//  SAMPLE_W    16         signed output sample width
//  VOL_STEP    15'h1FFF   volume increment/decrement per button pulse
//  VOL_RESET   15'h3FFF   volume after reset
//  SAMPLE_DIV  1042       CLOCK_50 cycles per output sample (~48 kHz)
// PORTS
//  CLOCK_50        in   1           system clock, 50 MHz
//  reset           in   1           asynchronous, active-high
//  data            in   8           PS/2 scan-code byte
//  valid_data      in   1           1-cycle strobe, data valid
//  vol_up          in   1           1-cycle pulse (synchronised button edge)
//  vol_down        in   1           1-cycle pulse
//  lookup_key      out  8           key code presented to note table (= data)
//  lookup_hp       in   HP_W        half period for lookup_key, same cycle; 0 = unmapped
//  square_wave     out  SAMPLE_W    signed mixed sample
//  wr              out  1           1-cycle sample strobe
//  active_mask     out  NUM_VOICES  bit i = voice i sounding
//  last_key        out  8           most recent accepted make code (for HEX display)
//  dropped         out  1           1-cycle pulse: make code rejected, all voices busy
// BEHAVIOUR
//  Reset: all voices free, counters/phases 0, parser IDLE, volume=VOL_RESET,
//   square_wave=0, wr=0, active_mask=0, last_key=8'h00, dropped=0, divider=0.
//  Parser FSM (advances only on valid_data):
//   IDLE:  F0 -> BREAK; E0 -> IDLE (ignored); other byte -> make event, IDLE.
//   BREAK: F0/E0 -> BREAK (stay); other byte -> break event, IDLE.
//  Make event (same cycle as valid_data; lookup_hp sampled that cycle):
//   lookup_hp==0 -> ignored. Key already held by a voice -> ignored (typematic).
//   Else lowest-index free voice takes key, half period latched, counter=0,
//   phase=1; active_mask bit set next cycle; last_key updated.
//   No free voice -> ignored, dropped pulses next cycle.
//  Break event: voice holding that key freed next cycle (bit cleared, phase=0);
//   no match -> ignored. Break never alters last_key.
//  Voice: active counter increments each cycle; at count==hp-1 counter->0 and
//   phase toggles (output period 2*hp cycles). Free voices hold counter at 0.
//  Volume: vol_up -> min(vol+VOL_STEP, 2^VOL_W-1); vol_down -> max(vol-VOL_STEP,0);
//   both in same cycle -> unchanged. No wrap-around in either direction.
//  Mixer: amp = volume >> log2(NUM_VOICES); per active voice +amp (phase 1) or
//   -amp (phase 0); free voices contribute 0; sum sign-extended to SAMPLE_W,
//   cannot overflow.
//  Sample timing: divider counts 0..SAMPLE_DIV-1; at SAMPLE_DIV-1 square_wave
//   is registered with the current mix and wr=1 for that one cycle.
//   square_wave holds between strobes; wr period exactly SAMPLE_DIV cycles.
//  Reset asserted mid-note or mid-BREAK returns everything to reset values
//   immediately; a pending F0 is discarded.
// TESTING
//  1) Reset, send 15 (lookup_hp=100) -> active_mask=0001, last_key=15, voice 0
//     toggles every 100 cycles; wr samples alternate +0x0FFF / -0x0FFF.
//  2) Send 15, then 15 again, then F0,15 -> second 15 ignored; mask 0001->0000;
//     next sample after release = 0.
//  3) Send 15,1D,24,2D,2C (all mapped) -> mask=1111, 5th make pulses dropped,
//     last_key=2D; F0,1D -> mask=1101; then 2C -> allocates voice 1.
//  4) From VOL_RESET pulse vol_up 3x -> 0x5FFE, 0x7FFD, 0x7FFF (saturated);
//     vol_down 5x -> floor at 0; vol_up+vol_down together -> no change.
//  5) Send unmapped byte (lookup_hp=0) and E0,15 -> unmapped ignored; E0
//     ignored, 15 allocates normally; F0,E0,15 releases 15.
//  6) Assert reset after F0 with two voices active -> mask=0, square_wave=0,
//     wr=0; following 15 is a make (not a break).

Source files
------------

// File: rtl/ps2_poly_synth.sv
// ps2_poly_synth: polyphonic square-wave synth driven by a PS/2 scan-code stream.
// Tracks make/break codes, allocates square-wave voices, and mixes them with a
// saturating volume control into a signed sample strobed at a fixed rate.
module ps2_poly_synth #(
   parameter int unsigned      NUM_VOICES = 4,
   parameter int unsigned      HP_W       = 21,
   parameter int unsigned      VOL_W      = 15,
   parameter int unsigned      SAMPLE_W   = 16,
   parameter logic [VOL_W-1:0] VOL_STEP   = VOL_W'('h1FFF),
   parameter logic [VOL_W-1:0] VOL_RESET  = VOL_W'('h3FFF),
   parameter int unsigned      SAMPLE_DIV = 1042
) (
   input  logic                       CLOCK_50,
   input  logic                       reset,
   input  logic [7:0]                 data,
   input  logic                       valid_data,
   input  logic                       vol_up,
   input  logic                       vol_down,
   output logic [7:0]                 lookup_key,
   input  logic [HP_W-1:0]            lookup_hp,
   output logic signed [SAMPLE_W-1:0] square_wave,
   output logic                       wr,
   output logic [NUM_VOICES-1:0]      active_mask,
   output logic [7:0]                 last_key,
   output logic                       dropped
);

   localparam int unsigned VI_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int unsigned AMP_SHIFT = $clog2(NUM_VOICES);
   localparam int unsigned DIV_W     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   localparam logic [VOL_W-1:0] VOL_MAX  = '1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

   localparam logic [7:0] CODE_BREAK = 8'hF0;
   localparam logic [7:0] CODE_EXT   = 8'hE0;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BREAK = 1'b1;

   logic [0:0]            state, state_nx;
   logic                  make_ev, break_ev;

   logic [7:0]            vkey [NUM_VOICES];
   logic [HP_W-1:0]       vhp  [NUM_VOICES];
   logic [HP_W-1:0]       vcnt [NUM_VOICES];
   logic [NUM_VOICES-1:0] phase;
   logic [NUM_VOICES-1:0] hit_vec;
   logic                  free_found;
   logic [VI_W-1:0]       free_idx;
   logic                  make_ok, alloc, drop;

   logic [VOL_W-1:0]      vol, vol_nx;
   logic [VOL_W-1:0]      amp;
   logic signed [SAMPLE_W-1:0] amp_s, mix;
   logic [DIV_W-1:0]      div;

   // The note table sees the raw byte so its answer is ready in the same cycle.
   assign lookup_key = data;

   // Parser state register.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   // Parser next state and make/break event decode; E0 prefixes are transparent.
   always_comb begin
      state_nx = state;
      make_ev  = 1'b0;
      break_ev = 1'b0;
      if (valid_data) begin
         case (state)
            ST_IDLE: begin
               if (data == CODE_BREAK)    state_nx = ST_BREAK;
               else if (data != CODE_EXT) make_ev  = 1'b1;
            end
            ST_BREAK: begin
               if (data != CODE_BREAK && data != CODE_EXT) begin
                  break_ev = 1'b1;
                  state_nx = ST_IDLE;
               end
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   // Key match against held voices and lowest-index free voice search.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
         hit_vec[i] = active_mask[i] && (vkey[i] == data);
      end
      for (int i = int'(NUM_VOICES) - 1; i >= 0; i--) begin
         if (!active_mask[i]) begin
            free_found = 1'b1;
            free_idx   = VI_W'(i);
         end
      end
   end

   // A mapped key that is not already sounding either gets a voice or is dropped.
   assign make_ok = make_ev && (lookup_hp != '0) && !(|hit_vec);
   assign alloc   = make_ok && free_found;
   assign drop    = make_ok && !free_found;

   // Voice allocation, release and half-period phase counters.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         active_mask <= '0;
         phase       <= '0;
         for (int i = 0; i < int'(NUM_VOICES); i++) begin
            vkey[i] <= '0;
            vhp[i]  <= '0;
            vcnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(NUM_VOICES); i++) begin
            if (alloc && free_idx == VI_W'(i)) begin
               active_mask[i] <= 1'b1;
               phase[i]       <= 1'b1;
               vkey[i]        <= data;
               vhp[i]         <= lookup_hp;
               vcnt[i]        <= '0;
            end else if (break_ev && hit_vec[i]) begin
               active_mask[i] <= 1'b0;
               phase[i]       <= 1'b0;
               vcnt[i]        <= '0;
            end else if (active_mask[i]) begin
               if (vcnt[i] == vhp[i] - HP_W'(1)) begin
                  vcnt[i]  <= '0;
                  phase[i] <= ~phase[i];
               end else begin
                  vcnt[i] <= vcnt[i] + HP_W'(1);
               end
            end
         end
      end
   end

   // Display key and overflow pulse.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         last_key <= 8'h00;
         dropped  <= 1'b0;
      end else begin
         dropped <= drop;
         if (alloc) last_key <= data;
      end
   end

   // Saturating volume update; simultaneous up and down cancel.
   always_comb begin
      vol_nx = vol;
      if (vol_up && !vol_down) begin
         if ((VOL_MAX - vol) < VOL_STEP) vol_nx = VOL_MAX;
         else                            vol_nx = vol + VOL_STEP;
      end else if (vol_down && !vol_up) begin
         if (vol < VOL_STEP) vol_nx = '0;
         else                vol_nx = vol - VOL_STEP;
      end
   end

   // Volume register.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) vol <= VOL_RESET;
      else       vol <= vol_nx;
   end

   // Per-voice amplitude is scaled so a full chord can never overflow the sample.
   assign amp   = vol >> AMP_SHIFT;
   assign amp_s = SAMPLE_W'(amp);

   // Mix: each sounding voice adds +amp or -amp depending on its phase.
   always_comb begin
      mix = '0;
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
         if (active_mask[i]) begin
            if (phase[i]) mix = mix + amp_s;
            else          mix = mix - amp_s;
         end
      end
   end

   // Sample-rate divider: capture the mix and strobe wr once per SAMPLE_DIV cycles.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         div         <= '0;
         wr          <= 1'b0;
         square_wave <= '0;
      end else if (div == DIV_LAST) begin
         div         <= '0;
         wr          <= 1'b1;
         square_wave <= mix;
      end else begin
         div <= div + DIV_W'(1);
         wr  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ps2_poly_synth.sv
// tb_ps2_poly_synth: directed + randomized bench with a timestamp-based voice model.
module tb_ps2_poly_synth;

   localparam int unsigned NV         = 4;
   localparam int unsigned HP_W       = 21;
   localparam int unsigned VOL_W      = 15;
   localparam int unsigned SAMPLE_W   = 16;
   localparam int          VSTEP      = 'h1FFF;
   localparam int          VRESET     = 'h3FFF;
   localparam int          VMAX       = (1 << VOL_W) - 1;
   localparam int unsigned SAMPLE_DIV = 1042;

   logic                       CLOCK_50 = 1'b0;
   logic                       reset    = 1'b0;
   logic [7:0]                 data     = '0;
   logic                       valid_data = 1'b0;
   logic                       vol_up   = 1'b0;
   logic                       vol_down = 1'b0;
   logic [7:0]                 lookup_key;
   logic [HP_W-1:0]            lookup_hp = '0;
   logic signed [SAMPLE_W-1:0] square_wave;
   logic                       wr;
   logic [NV-1:0]              active_mask;
   logic [7:0]                 last_key;
   logic                       dropped;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;

   // Reference model: voice ownership with start edge, parser flag, volume.
   bit m_act   [NV];
   int m_key   [NV];
   int m_hp    [NV];
   int m_start [NV];
   bit m_brk;
   int m_last;
   int m_vol;

   ps2_poly_synth dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .data        (data),
      .valid_data  (valid_data),
      .vol_up      (vol_up),
      .vol_down    (vol_down),
      .lookup_key  (lookup_key),
      .lookup_hp   (lookup_hp),
      .square_wave (square_wave),
      .wr          (wr),
      .active_mask (active_mask),
      .last_key    (last_key),
      .dropped     (dropped)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   // Edge counter used to timestamp model events.
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int exp_mask();
      int m = 0;
      for (int v = 0; v < int'(NV); v++) if (m_act[v]) m |= (1 << v);
      return m;
   endfunction

   // Expected mix from the state that exists after edge m.
   function automatic int exp_mix(int m);
      int amp = m_vol / int'(NV);
      int s = 0;
      for (int v = 0; v < int'(NV); v++) begin
         if (m_act[v]) begin
            if (((m - m_start[v]) / m_hp[v]) % 2 == 0) s += amp;
            else                                        s -= amp;
         end
      end
      return s;
   endfunction

   function automatic bit held(int k);
      for (int v = 0; v < int'(NV); v++) if (m_act[v] && m_key[v] == k) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int first_free();
      for (int v = 0; v < int'(NV); v++) if (!m_act[v]) return v;
      return -1;
   endfunction

   task automatic model_reset();
      for (int v = 0; v < int'(NV); v++) begin
         m_act[v] = 1'b0; m_key[v] = 0; m_hp[v] = 1; m_start[v] = 0;
      end
      m_brk = 1'b0; m_last = 0; m_vol = VRESET;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #3;
      chk("rst_mask", active_mask, 0);
      chk("rst_sample", square_wave, 0);
      chk("rst_wr", wr, 0);
      chk("rst_last_key", last_key, 0);
      chk("rst_dropped", dropped, 0);
      model_reset();
      @(posedge CLOCK_50); #1;
      reset = 1'b0;
   endtask

   // Present one byte for one cycle, update the model, check the registered outcome.
   task automatic send(input int b, input int hp);
      int e, idx;
      bit exp_drop;
      data = 8'(b); lookup_hp = HP_W'(hp); valid_data = 1'b1;
      #1;
      chk("lookup_key", lookup_key, b);
      @(posedge CLOCK_50); #1;
      valid_data = 1'b0;
      e = cyc;
      exp_drop = 1'b0;
      if (!m_brk) begin
         if (b == 'hF0) m_brk = 1'b1;
         else if (b != 'hE0 && hp != 0 && !held(b)) begin
            idx = first_free();
            if (idx >= 0) begin
               m_act[idx] = 1'b1; m_key[idx] = b; m_hp[idx] = hp; m_start[idx] = e; m_last = b;
            end else exp_drop = 1'b1;
         end
      end else if (b != 'hF0 && b != 'hE0) begin
         m_brk = 1'b0;
         for (int v = 0; v < int'(NV); v++) if (m_act[v] && m_key[v] == b) m_act[v] = 1'b0;
      end
      chk("dropped", dropped, exp_drop);
      chk("active_mask", active_mask, exp_mask());
      chk("last_key", last_key, m_last);
   endtask

   task automatic vol_pulse(input bit up, input bit down);
      vol_up = up; vol_down = down;
      @(posedge CLOCK_50); #1;
      vol_up = 1'b0; vol_down = 1'b0;
      if (up && !down)      m_vol = (m_vol + VSTEP > VMAX) ? VMAX : m_vol + VSTEP;
      else if (down && !up) m_vol = (m_vol - VSTEP < 0) ? 0 : m_vol - VSTEP;
   endtask

   // Wait for n wr strobes (bounded) and compare each sample and strobe spacing.
   task automatic check_samples(input int n);
      int prev = -1;
      bit got;
      @(posedge CLOCK_50); #1;
      for (int k = 0; k < n; k++) begin
         got = 1'b0;
         for (int c = 0; c < 2 * int'(SAMPLE_DIV) && !got; c++) begin
            @(posedge CLOCK_50); #1;
            if (wr === 1'b1) got = 1'b1;
         end
         if (!got) chk("wr_timeout", wr, 1);
         else begin
            chk("sample", square_wave, exp_mix(cyc - 1));
            if (prev >= 0) chk("wr_period", cyc - prev, int'(SAMPLE_DIV));
            prev = cyc;
         end
      end
   endtask

   initial begin
      int b, hp;
      model_reset();
      #1;
      do_reset();

      // Single voice
      send('h15, 100);
      check_samples(4);

      // Typematic repeat ignored, then release
      send('h15, 100);
      send('hF0, 0);
      send('h15, 100);
      check_samples(2);

      // Fill all voices, overflow, release middle, reallocate
      send('h15, $urandom_range(50, 500));
      send('h1D, $urandom_range(50, 500));
      send('h24, $urandom_range(50, 500));
      send('h2D, $urandom_range(50, 500));
      send('h2C, $urandom_range(50, 500));
      check_samples(2);
      send('hF0, 0);
      send('h1D, 0);
      send('h2C, $urandom_range(50, 500));
      check_samples(2);

      // Volume saturation in both directions
      do_reset();
      send('h15, $urandom_range(30, 300));
      for (int i = 0; i < 3; i++) begin vol_pulse(1'b1, 1'b0); check_samples(1); end
      for (int i = 0; i < 5; i++) begin vol_pulse(1'b0, 1'b1); check_samples(1); end
      vol_pulse(1'b1, 1'b0);
      vol_pulse(1'b1, 1'b1);
      check_samples(1);

      // Unmapped key, extended prefix, extended release; hp=1 boundary
      send('h3B, 0);
      send('hE0, 0);
      send('h1C, 1);
      check_samples(2);
      send('hF0, 0);
      send('hE0, 0);
      send('h1C, 0);
      check_samples(1);

      // Random byte stream
      for (int i = 0; i < 16; i++) begin
         b  = int'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) == 0) ? 'hF0 : 'hE0;
         hp = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 700));
         send(b, hp);
         if (i % 4 == 3) check_samples(1);
      end
      check_samples(2);

      // Reset in the middle of a pending break
      do_reset();
      send('h15, 120);
      send('h1D, 90);
      send('hF0, 0);
      repeat (5) @(posedge CLOCK_50);
      #1;
      do_reset();
      send('h15, 120);
      check_samples(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
